// File: rtl/rca_word_sequencer_if.sv
// Requester-side bundle for the nibble-serial add/subtract sequencer.
// The master modport is the requester, the slave modport is the sequencer.
interface rca_word_sequencer_if #(
   parameter int NIBBLES = 4
) ();
   localparam int W = 4 * NIBBLES;

   logic         start;
   logic         sub;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         carry_out;
   logic         overflow;

   modport master (
      output start, sub, op_a, op_b,
      input  ready, busy, done, result, carry_out, overflow
   );

   modport slave (
      input  start, sub, op_a, op_b,
      output ready, busy, done, result, carry_out, overflow
   );
endinterface

// File: rtl/rca_word_sequencer.sv
// Multi-cycle add/subtract: one 4-bit ripple slice reused per nibble, LSB first,
// with a registered carry chaining the nibbles together.
module rca_word_sequencer #(
   parameter int NIBBLES = 4
) (
   input logic              clk,
   input logic              rst_n,
   rca_word_sequencer_if.slave bus
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [IW-1:0] idx;
   logic          carry_q;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [W-1:0]  work_q;
   logic [W-1:0]  result_q;
   logic          carry_out_q;
   logic          overflow_q;
   logic          done_q;
   logic [3:0]    a_nib;
   logic [3:0]    b_nib;
   logic [4:0]    sum5;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.start) state_nxt = S_RUN;
         S_RUN:   if (idx == LAST_IDX) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.ready = (state == S_IDLE);
      bus.busy  = (state != S_IDLE);
   end

   // Single shared slice: operand B is stored pre-inverted for subtraction.
   always_comb begin
      a_nib = a_q[{idx, 2'b00} +: 4];
      b_nib = b_q[{idx, 2'b00} +: 4];
      sum5  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx         <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         work_q      <= '0;
         result_q    <= '0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  a_q     <= bus.op_a;
                  b_q     <= bus.sub ? ~bus.op_b : bus.op_b;
                  carry_q <= bus.sub;
                  idx     <= '0;
               end
            end
            S_RUN: begin
               work_q[{idx, 2'b00} +: 4] <= sum5[3:0];
               carry_q                   <= sum5[4];
               if (idx != LAST_IDX) idx <= idx + IW'(1);
            end
            S_DONE: begin
               result_q    <= work_q;
               carry_out_q <= carry_q;
               overflow_q  <= (a_q[W-1] == b_q[W-1]) && (work_q[W-1] != a_q[W-1]);
               done_q      <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.done      = done_q;
   assign bus.result    = result_q;
   assign bus.carry_out = carry_out_q;
   assign bus.overflow  = overflow_q;
endmodule
